// File: rtl/ldpc_llr_loader.sv
// ldpc_llr_loader
//   Input stage of the LDPC decoder core. Channel LLRs arrive as beats of P
//   signed in_w-bit samples. Each sample is arithmetically shifted right by
//   FRAC and symmetrically saturated to data_w bits. The value -2^(data_w-1)
//   is never produced. NB = R*D/P beats make up one frame.
//   A fill buffer collects the frame. A separate output register holds the
//   frame the core is decoding, so the next frame can load in the meantime.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   in_valid     input beat valid
//   in_ready     loader can accept a beat (low while the fill buffer holds
//                a complete frame that has not been transferred yet)
//   in_data      P samples, lane p at [p*in_w +: in_w]
//   in_last      marks the final beat of a frame
//   frame_sig    assembled frame, sample n at [n*data_w +: data_w]
//   frame_valid  frame_sig holds a complete frame the core has not consumed
//   frame_ack    consumer has latched frame_sig
//   err_len      one-cycle pulse when in_last does not line up with beat NB-1
//
// Handshakes
//   Input:  a beat transfers on a rising edge where in_valid & in_ready.
//           in_data and in_last are ignored while in_ready is low.
//   Output: a frame is consumed on a rising edge where frame_valid &
//           frame_ack. frame_ack is ignored while frame_valid is low.
module ldpc_llr_loader #(
    parameter int data_w = 5,
    parameter int in_w   = 8,
    parameter int FRAC   = 2,
    parameter int R      = 24,
    parameter int D      = 96,
    parameter int P      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [P*in_w-1:0]       in_data,
    input  logic                    in_last,
    output logic [R*D*data_w-1:0]   frame_sig,
    output logic                    frame_valid,
    input  logic                    frame_ack,
    output logic                    err_len
);

    localparam int N       = R * D;
    localparam int NB      = N / P;
    localparam int FRAME_W = N * data_w;
    localparam int BEAT_W  = P * data_w;
    localparam int CNT_W   = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NB - 1);

    // Saturation limits, in both the input and the output width.
    localparam logic signed [in_w-1:0]   LIM_IN   = in_w'((1 << (data_w - 1)) - 1);
    localparam logic signed [in_w-1:0]   NLIM_IN  = -LIM_IN;
    localparam logic signed [data_w-1:0] LIM_OUT  = data_w'((1 << (data_w - 1)) - 1);
    localparam logic signed [data_w-1:0] NLIM_OUT = -LIM_OUT;

    logic [FRAME_W-1:0] fill_buf;
    logic [BEAT_W-1:0]  beat_conv;
    logic [CNT_W-1:0]   beat_cnt;
    logic               stage_full;
    logic               accept;
    logic               transfer;

    function automatic logic [data_w-1:0] scale_sat(input logic [in_w-1:0] x);
        logic signed [in_w-1:0] t;
        logic [data_w-1:0]      r;
        t = $signed(x) >>> FRAC;
        if (t > LIM_IN) begin
            r = LIM_OUT;
        end else if (t < NLIM_IN) begin
            r = NLIM_OUT;
        end else begin
            r = t[data_w-1:0];
        end
        return r;
    endfunction

    always_comb begin
        beat_conv = '0;
        for (int p = 0; p < P; p++) begin
            beat_conv[p*data_w +: data_w] = scale_sat(in_data[p*in_w +: in_w]);
        end
    end

    assign in_ready = ~stage_full;
    assign accept   = in_valid & in_ready;
    // A transfer needs stage_full, and acceptance needs ~stage_full, so
    // the two never happen on the same edge.
    assign transfer = stage_full & (~frame_valid | frame_ack);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_buf    <= '0;
            beat_cnt    <= '0;
            stage_full  <= 1'b0;
            frame_sig   <= '0;
            frame_valid <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            err_len <= 1'b0;

            if (accept) begin
                // Beats arrive in order, so shifting each one in at the top
                // leaves beat 0 at the bottom after NB beats. Sample b*P+p
                // therefore ends at [(b*P+p)*data_w]. A dropped partial
                // frame is pushed out completely by the next full frame.
                fill_buf <= {beat_conv, fill_buf[FRAME_W-1:BEAT_W]};
                if (beat_cnt == LAST_BEAT) begin
                    beat_cnt   <= '0;
                    stage_full <= 1'b1;
                    err_len    <= ~in_last;
                end else if (in_last) begin
                    beat_cnt <= '0;
                    err_len  <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end

            if (transfer) begin
                frame_sig   <= fill_buf;
                frame_valid <= 1'b1;
                stage_full  <= 1'b0;
            end else if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_llr_loader.sv
module tb_ldpc_llr_loader;

    localparam int DW      = 5;
    localparam int IW      = 8;
    localparam int R       = 24;
    localparam int D       = 96;
    localparam int P       = 8;
    localparam int N       = R * D;
    localparam int NB      = N / P;
    localparam int FRAME_W = N * DW;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [P*IW-1:0]    in_data = '0;
    logic               in_last = 1'b0;
    logic [FRAME_W-1:0] frame_sig;
    logic               frame_valid;
    logic               frame_ack = 1'b0;
    logic               err_len;

    ldpc_llr_loader #(
        .data_w(DW), .in_w(IW), .FRAC(2), .R(R), .D(D), .P(P)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .frame_sig(frame_sig),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .err_len(err_len)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Hand-computed vectors: input samples and their scaled/saturated values.
    int tin[3][8] = '{
        '{4, 4, 4, 4, 4, 4, 4, 4},
        '{127, -128, -63, 63, -64, 64, 3, -3},
        '{4, 8, -4, -8, 0, 1, -1, 60}
    };
    int tout[3][8] = '{
        '{1, 1, 1, 1, 1, 1, 1, 1},
        '{15, -15, -15, 15, -15, 15, 0, -1},
        '{1, 2, -1, -2, 0, 0, -1, 15}
    };

    logic [FRAME_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_frames = 0;
    int err_cnt  = 0;
    int err_base;

    // mode 0: all 4s; mode 1/2: rotating tables; mode 3: table 1, other order
    function automatic int tbl_of(input int mode);
        return (mode == 3) ? 1 : mode;
    endfunction

    function automatic int idx_of(input int mode, input int b, input int p);
        return (mode == 3) ? ((3 * b + p) % 8) : ((b + p) % 8);
    endfunction

    function automatic logic [P*IW-1:0] beat_in(input int mode, input int b);
        logic [P*IW-1:0] d;
        d = '0;
        for (int p = 0; p < P; p++) d[p*IW +: IW] = IW'(tin[tbl_of(mode)][idx_of(mode, b, p)]);
        return d;
    endfunction

    function automatic logic [FRAME_W-1:0] make_exp(input int mode);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < P; p++)
                f[(b*P+p)*DW +: DW] = DW'(tout[tbl_of(mode)][idx_of(mode, b, p)]);
        return f;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_frame(input string name, input logic [FRAME_W-1:0] act,
                               input logic [FRAME_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            for (int n = 0; n < N; n++) begin
                if (act[n*DW +: DW] !== exp[n*DW +: DW]) begin
                    $display("FAIL %s: sample %0d got %0d expected %0d", name, n,
                             $signed(act[n*DW +: DW]), $signed(exp[n*DW +: DW]));
                    break;
                end
            end
        end
    endtask

    // scoreboard monitor: a new frame is on the bus when frame_valid rises,
    // or stays high right after an edge that consumed the previous frame
    logic pv = 1'b0;
    logic pc = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            pv = 1'b0;
            pc = 1'b0;
        end else begin
            if (frame_valid && (!pv || pc)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL frame_unexpected: frame presented with empty expected queue");
                end else begin
                    n_frames++;
                    check_frame("frame_data", frame_sig, exp_q.pop_front());
                end
            end
            pv = frame_valid;
            pc = frame_valid & frame_ack;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && err_len === 1'b1) err_cnt++;
    end

    // driver tasks
    task automatic send_beat(input logic [P*IW-1:0] d, input logic last);
        logic ready_now;
        int   waited;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        waited   = 0;
        do begin
            ready_now = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end while (!ready_now && waited < 2000);
        if (!ready_now) begin
            n_checks++;
            $display("FAIL beat_accept_timeout: in_ready stayed %0d for %0d cycles", in_ready, waited);
        end
    endtask

    task automatic send_frame(input int mode, input int nbeats, input int last_at);
        for (int b = 0; b < nbeats; b++) send_beat(beat_in(mode, b), b == last_at);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack;
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
    endtask

    initial begin
        // reset
        idle(3);
        rst = 1'b1;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_len", err_len, 0);
        check("rst_frame_sig_zero", (frame_sig == '0) ? 1 : 0, 1);

        // 1: all lanes 4, latency of two edges after the last beat
        exp_q.push_back(make_exp(0));
        send_frame(0, NB, NB - 1);
        check("t1_valid_after_E", frame_valid, 0);
        check("t1_ready_after_E", in_ready, 0);
        idle(1);
        check("t1_valid_after_E1", frame_valid, 1);
        check("t1_ready_after_E1", in_ready, 1);
        idle(1);
        check("t1_err_count", err_cnt, 0);
        pulse_ack();
        check("t1_valid_after_ack", frame_valid, 0);

        // 2: saturation frame, left unacknowledged
        exp_q.push_back(make_exp(1));
        send_frame(1, NB, NB - 1);
        idle(2);
        check("t2_valid", frame_valid, 1);

        // 3: second frame behind an unacknowledged one
        exp_q.push_back(make_exp(2));
        send_frame(2, NB, NB - 1);
        check("t3_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_data  = '0;
        in_last  = 1'b1;
        idle(3);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t3_ready_still_low", in_ready, 0);
        check("t3_err_while_blocked", err_cnt, 0);
        check_frame("t3_frame_held", frame_sig, make_exp(1));
        pulse_ack();
        check("t3_valid_no_bubble", frame_valid, 1);
        check("t3_ready_back", in_ready, 1);
        idle(1);
        pulse_ack();
        check("t3_valid_cleared", frame_valid, 0);

        // 4: early in_last drops the partial frame
        err_base = err_cnt;
        send_frame(3, 11, 10);
        idle(3);
        check("t4_err_one_cycle", err_cnt - err_base, 1);
        check("t4_no_frame", frame_valid, 0);
        exp_q.push_back(make_exp(3));
        send_frame(3, NB, NB - 1);
        idle(2);
        check("t4_clean_err", err_cnt - err_base, 1);
        pulse_ack();

        // 5: missing in_last still delivers the frame
        err_base = err_cnt;
        exp_q.push_back(make_exp(1));
        send_frame(1, NB, -1);
        idle(2);
        check("t5_err_pulse", err_cnt - err_base, 1);
        check("t5_valid", frame_valid, 1);
        pulse_ack();
        exp_q.push_back(make_exp(2));
        send_frame(2, NB, NB - 1);
        idle(2);
        check("t5_next_no_err", err_cnt - err_base, 1);
        pulse_ack();

        // 6: reset in the middle of a frame
        err_base = err_cnt;
        send_frame(0, 100, -1);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        check("t6_valid", frame_valid, 0);
        check("t6_frame_sig_zero", (frame_sig == '0) ? 1 : 0, 1);
        check("t6_ready", in_ready, 1);
        idle(2);
        check("t6_no_err", err_cnt - err_base, 0);
        exp_q.push_back(make_exp(3));
        send_frame(3, NB, NB - 1);
        idle(2);
        check("t6_valid_after_reload", frame_valid, 1);
        pulse_ack();
        idle(2);

        // final report
        check("frames_seen", n_frames, 7);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
